// File: rtl/mult_share_arbiter.sv
// Round-robin front end sharing one iterative shift-add multiplier between two
// requesters; the product returns on a valid/ready channel tagged with the owner id.
module mult_share_arbiter #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           req1_ready,
    output logic           res_valid,
    output logic [2*N-1:0] res_z,
    output logic           res_id,
    input  logic           res_ready,
    output logic           busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state, state_nxt;
    logic [2*N-1:0] acc, a_reg;
    logic [N-1:0]   b_reg;
    logic [CW-1:0]  cnt;
    logic           last_id;
    logic           gnt, accept;

    // Grant is only meaningful in IDLE; readies are gated by state below.
    always_comb begin
        gnt        = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (req0_valid && req1_valid) gnt = ~last_id;
        else if (req1_valid)          gnt = 1'b1;
        if (state == IDLE) begin
            req0_ready = req0_valid && !gnt;
            req1_ready = req1_valid &&  gnt;
        end
    end

    assign accept = req0_ready | req1_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (cnt == CW'(N-1)) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            cnt       <= '0;
            res_id    <= 1'b0;
            res_valid <= 1'b0;
            last_id   <= 1'b1;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    a_reg   <= {{N{1'b0}}, (gnt ? req1_a : req0_a)};
                    b_reg   <= gnt ? req1_b : req0_b;
                    acc     <= '0;
                    cnt     <= '0;
                    res_id  <= gnt;
                    last_id <= gnt;
                end
                BUSY: begin
                    // One multiplier bit per clock: conditional add, then shift.
                    if (b_reg[0]) acc <= acc + a_reg;
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(N-1)) res_valid <= 1'b1;
                end
                DONE: if (res_ready) res_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign res_z = acc;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: N=4 main instance plus an N=8 instance
// for the wide extreme case.
module tb_mult_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       res_valid, res_id, res_ready, busy;
    logic [7:0] res_z;

    logic        w0_valid, w0_ready, w1_ready, wres_valid, wres_id, wres_ready, wbusy;
    logic [7:0]  w0_a, w0_b;
    logic [15:0] wres_z;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult_share_arbiter #(.N(4), .CW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_z(res_z), .res_id(res_id), .res_ready(res_ready),
        .busy(busy)
    );

    mult_share_arbiter #(.N(8), .CW(4)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(w0_valid), .req0_a(w0_a), .req0_b(w0_b), .req0_ready(w0_ready),
        .req1_valid(1'b0), .req1_a(8'd0), .req1_b(8'd0), .req1_ready(w1_ready),
        .res_valid(wres_valid), .res_z(wres_z), .res_id(wres_id), .res_ready(wres_ready),
        .busy(wbusy)
    );

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; res_ready = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        w0_valid = 0; w0_a = 0; w0_b = 0; wres_ready = 0;
        repeat (2) step();
        rst_n = 1'b1;
        #1;
    endtask

    // Advances until res_valid or the bound expires; k is the number of edges taken.
    task automatic wait_res(output int k);
        k = 0;
        while (!res_valid && k < 20) begin step(); k++; end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (res_z !== 8'd0) begin n_bad++; $display("FAIL reset_res_z: got %0d want 0", res_z); end
        n_cmp++; if (res_id !== 1'b0) begin n_bad++; $display("FAIL reset_res_id: got %b want 0", res_id); end
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
    endtask

    task automatic test_single();
        int k;
        do_reset();
        res_ready = 1; req0_valid = 1; req0_a = 13; req0_b = 11;
        #1;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); end
        step();
        req0_valid = 0; req0_a = 0; req0_b = 0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
        wait_res(k);
        n_cmp++; if (k !== 4) begin n_bad++; $display("FAIL single_latency: got %0d want 4", k); end
        n_cmp++; if (res_z !== 8'd143) begin n_bad++; $display("FAIL single_z: got %0d want 143", res_z); end
        n_cmp++; if (res_id !== 1'b0) begin n_bad++; $display("FAIL single_id: got %b want 0", res_id); end
        step();
        n_cmp++; if ({res_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL single_after_hs: got %b want 00", {res_valid, busy}); end
    endtask

    task automatic test_contention();
        int k;
        logic stalled_ok;
        do_reset();
        res_ready = 1;
        req0_valid = 1; req0_a = 3; req0_b = 5;
        req1_valid = 1; req1_a = 7; req1_b = 9;
        #1;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL cont_first_grant: got %b want 10", {req0_ready, req1_ready}); end
        step();
        req0_valid = 0;
        stalled_ok = 1'b1;
        k = 0;
        while (!res_valid && k < 20) begin
            if (req1_ready !== 1'b0) stalled_ok = 1'b0;
            step(); k++;
        end
        if (req1_ready !== 1'b0) stalled_ok = 1'b0;
        n_cmp++; if (stalled_ok !== 1'b1) begin n_bad++; $display("FAIL cont_req1_stall: got %b want 1", stalled_ok); end
        n_cmp++; if (res_z !== 8'd15 || res_id !== 1'b0) begin n_bad++; $display("FAIL cont_res0: got z=%0d id=%b want z=15 id=0", res_z, res_id); end
        step();
        n_cmp++; if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL cont_req1_grant: got %b want 1", req1_ready); end
        step();
        req1_valid = 0;
        wait_res(k);
        n_cmp++; if (res_valid !== 1'b1 || res_z !== 8'd63 || res_id !== 1'b1) begin n_bad++; $display("FAIL cont_res1: got v=%b z=%0d id=%b want v=1 z=63 id=1", res_valid, res_z, res_id); end
        step();
    endtask

    task automatic test_fairness();
        int k;
        logic [7:0] exp_z;
        do_reset();
        res_ready = 1;
        req0_valid = 1; req0_a = 2; req0_b = 3;
        req1_valid = 1; req1_a = 5; req1_b = 6;
        for (int i = 0; i < 6; i++) begin
            wait_res(k);
            exp_z = (i % 2 == 0) ? 8'd6 : 8'd30;
            n_cmp++; if (res_valid !== 1'b1 || res_id !== 1'(i % 2) || res_z !== exp_z) begin
                n_bad++; $display("FAIL fair_%0d: got v=%b id=%b z=%0d want v=1 id=%0d z=%0d", i, res_valid, res_id, res_z, i % 2, exp_z);
            end
            step();
        end
        req0_valid = 0; req1_valid = 0;
        step();
        wait_res(k);
        step();
    endtask

    task automatic test_backpressure();
        int k;
        do_reset();
        req0_valid = 1; req0_a = 6; req0_b = 7;
        step();
        req0_valid = 0;
        wait_res(k);
        req1_valid = 1; req1_a = 1; req1_b = 1;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (res_valid !== 1'b1 || res_z !== 8'd42 || res_id !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_bad++; $display("FAIL bp_hold_%0d: got v=%b z=%0d id=%b rdy=%b%b want v=1 z=42 id=0 rdy=00", i, res_valid, res_z, res_id, req0_ready, req1_ready);
            end
            step();
        end
        res_ready = 1;
        step();
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup: got %b want 0", res_valid); end
        n_cmp++; if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL bp_stalled_req1: got %b want 1", req1_ready); end
        step();
        req1_valid = 0;
        wait_res(k);
        n_cmp++; if (res_valid !== 1'b1 || res_z !== 8'd1 || res_id !== 1'b1) begin n_bad++; $display("FAIL bp_req1_res: got v=%b z=%0d id=%b want v=1 z=1 id=1", res_valid, res_z, res_id); end
        step();
    endtask

    task automatic test_reset_midop();
        int k;
        do_reset();
        res_ready = 1;
        req1_valid = 1; req1_a = 9; req1_b = 9;
        step();
        req1_valid = 0;
        step(); step();
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({res_valid, busy, res_id, req0_ready, req1_ready} !== 5'b0 || res_z !== 8'd0) begin
            n_bad++; $display("FAIL midop_abort: got v=%b busy=%b id=%b z=%0d want all 0", res_valid, busy, res_id, res_z);
        end
        #3 rst_n = 1'b1;
        req0_valid = 1; req0_a = 3; req0_b = 3;
        req1_valid = 1; req1_a = 2; req1_b = 2;
        #1;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL midop_regrant: got %b want 10", {req0_ready, req1_ready}); end
        step();
        req0_valid = 0;
        wait_res(k);
        n_cmp++; if (res_valid !== 1'b1 || res_z !== 8'd9 || res_id !== 1'b0) begin n_bad++; $display("FAIL midop_first: got v=%b z=%0d id=%b want v=1 z=9 id=0", res_valid, res_z, res_id); end
        step(); step();
        req1_valid = 0;
        wait_res(k);
        n_cmp++; if (res_valid !== 1'b1 || res_z !== 8'd4 || res_id !== 1'b1) begin n_bad++; $display("FAIL midop_second: got v=%b z=%0d id=%b want v=1 z=4 id=1", res_valid, res_z, res_id); end
        step();
    endtask

    task automatic test_extremes();
        logic [3:0] ta [3];
        logic [3:0] tb [3];
        logic [7:0] tz [3];
        int k;
        ta = '{4'd15, 4'd0, 4'd15};
        tb = '{4'd15, 4'd15, 4'd0};
        tz = '{8'd225, 8'd0, 8'd0};
        do_reset();
        res_ready = 1;
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1; req0_a = ta[i]; req0_b = tb[i];
            step();
            req0_valid = 0;
            wait_res(k);
            n_cmp++; if (res_valid !== 1'b1 || k !== 4 || res_z !== tz[i]) begin
                n_bad++; $display("FAIL extreme_%0d: got v=%b lat=%0d z=%0d want v=1 lat=4 z=%0d", i, res_valid, k, res_z, tz[i]);
            end
            step();
        end
        wres_ready = 1; w0_valid = 1; w0_a = 8'd255; w0_b = 8'd255;
        step();
        w0_valid = 0;
        k = 0;
        while (!wres_valid && k < 30) begin step(); k++; end
        n_cmp++; if (wres_valid !== 1'b1 || k !== 8 || wres_z !== 16'd65025) begin
            n_bad++; $display("FAIL extreme_n8: got v=%b lat=%0d z=%0d want v=1 lat=8 z=65025", wres_valid, k, wres_z);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_backpressure();
        test_reset_midop();
        test_extremes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
